// File: rtl/p_to_s_pkg.sv
// Shared definitions for the p_to_s parallel-to-serial converter.
//   state_t    : shifter state (IDLE = no serial output, SHIFT = word on the wire)
//   cnt_width  : width of the bit counter for a given word width
package p_to_s_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bit counter spans 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/p_to_s.sv
// p_to_s: parallel-to-serial converter with a one-word holding register.
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per cycle on a serial valid/ready stream with a last-bit marker. The holding
// register lets the next word be taken while the current one shifts out, so
// back-to-back words stream without idle cycles.
//
// Parameters
//   WIDTH     : word width in bits (>= 2)
//   LSB_FIRST : 1 = bit 0 sent first, 0 = bit WIDTH-1 sent first
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   valid_a  in   parallel word valid
//   data_a   in   parallel word
//   ready_a  out  converter can accept a word (registered)
//   valid_b  out  serial bit valid (registered)
//   data_b   out  serial bit (registered)
//   last_b   out  serial bit is the final bit of its word (registered)
//   ready_b  in   downstream accepts the serial bit
module p_to_s
   import p_to_s_pkg::*;
#(
   parameter int WIDTH     = 6,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             ready_a,
   output logic             valid_b,
   output logic             data_b,
   output logic             last_b,
   input  logic             ready_b
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [WIDTH-1:0] word, word_next;
   logic [WIDTH-1:0] hold_data, hold_data_next;
   logic             hold_valid, hold_valid_next;
   logic             in_xfer, out_xfer;

   // Serial bit order is chosen by indexing the held word with the counter.
   function automatic logic bit_sel(input logic [WIDTH-1:0] w,
                                    input logic [CNT_W-1:0] c);
      if (LSB_FIRST)
         return w[c];
      else
         return w[LAST_CNT - c];
   endfunction

   assign valid_b  = (state == SHIFT);
   assign in_xfer  = valid_a & ready_a;
   assign out_xfer = valid_b & ready_b;

   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      word_next       = word;
      hold_data_next  = hold_data;
      hold_valid_next = hold_valid;

      unique case (state)
         IDLE: begin
            if (in_xfer) begin
               word_next  = data_a;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            if (out_xfer && (cnt == LAST_CNT)) begin
               cnt_next = '0;
               if (hold_valid) begin
                  // Hold word moves to the shifter; a same-cycle input
                  // transfer refills the holding register.
                  word_next       = hold_data;
                  hold_valid_next = 1'b0;
                  if (in_xfer) begin
                     hold_data_next  = data_a;
                     hold_valid_next = 1'b1;
                  end
               end else if (in_xfer) begin
                  word_next = data_a;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               if (out_xfer)
                  cnt_next = cnt + 1'b1;
               if (in_xfer) begin
                  hold_data_next  = data_a;
                  hold_valid_next = 1'b1;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Control and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         hold_valid <= 1'b0;
         ready_a    <= 1'b0;
         data_b     <= 1'b0;
         last_b     <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         hold_valid <= hold_valid_next;
         ready_a    <= !hold_valid_next;
         last_b     <= (state_next == SHIFT) && (cnt_next == LAST_CNT);
         // Only a transfer can change the presented bit; otherwise hold it.
         if (in_xfer || out_xfer)
            data_b <= bit_sel(word_next, cnt_next);
      end
   end

   // Word storage carries no reset; its validity is tracked by state/hold_valid.
   always_ff @(posedge clk) begin
      word      <= word_next;
      hold_data <= hold_data_next;
   end

endmodule

// File: tb/tb_p_to_s.sv
// Testbench for p_to_s: two instances (LSB-first and MSB-first) share the
// stimulus; a scoreboard queues expected bits per accepted word and compares
// them as serial transfers occur, while table rows and hand sequences check
// timing, markers and handshake behaviour.
module tb_p_to_s;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_a;
   logic [5:0] data_a;
   logic       ready_b;
   logic       ready_a_l, valid_b_l, data_b_l, last_b_l;
   logic       ready_a_m, valid_b_m, data_b_m, last_b_m;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int n_out_l  = 0;

   logic [1:0] ql[$];
   logic [1:0] qm[$];

   always #5 clk = ~clk;

   p_to_s #(.WIDTH(6), .LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst(rst), .valid_a(valid_a), .data_a(data_a),
      .ready_a(ready_a_l), .valid_b(valid_b_l), .data_b(data_b_l),
      .last_b(last_b_l), .ready_b(ready_b)
   );

   p_to_s #(.WIDTH(6), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .valid_a(valid_a), .data_a(data_a),
      .ready_a(ready_a_m), .valid_b(valid_b_m), .data_b(data_b_m),
      .last_b(last_b_m), .ready_b(ready_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable at the falling edge, so the values seen
   // here are the ones the next rising edge will act on.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst) begin
         ql.delete();
         qm.delete();
      end else begin
         if (valid_a && ready_a_l)
            for (int i = 0; i < 6; i++) ql.push_back({data_a[i], (i == 5)});
         if (valid_a && ready_a_m)
            for (int i = 0; i < 6; i++) qm.push_back({data_a[5-i], (i == 5)});
         if (valid_b_l && ready_b) begin
            n_out_l++;
            if (ql.size() == 0) begin
               check("sb_l_unexpected_bit", 1, 0);
            end else begin
               e = ql.pop_front();
               check("sb_l_data", data_b_l, e[1]);
               check("sb_l_last", last_b_l, e[0]);
            end
         end
         if (valid_b_m && ready_b) begin
            if (qm.size() == 0) begin
               check("sb_m_unexpected_bit", 1, 0);
            end else begin
               e = qm.pop_front();
               check("sb_m_data", data_b_m, e[1]);
               check("sb_m_last", last_b_m, e[0]);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // Sent-order patterns: first bit on the wire is the MSB of exp_l / exp_m.
   typedef struct {
      logic [5:0] word;
      logic [5:0] exp_l;
      logic [5:0] exp_m;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [5:0]  seq_l, seq_m, last_s, vld_s;
      logic [5:0]  words[3];
      logic [17:0] rdy_mask, last_mask;
      int          idx, nv, gaps;
      bit          seen_end, acc;

      tbl[0] = '{6'b101100, 6'b001101, 6'b101100};
      tbl[1] = '{6'h2A,     6'b010101, 6'b101010};
      tbl[2] = '{6'h15,     6'b101010, 6'b010101};
      tbl[3] = '{6'h3F,     6'b111111, 6'b111111};
      tbl[4] = '{6'b000001, 6'b100000, 6'b000001};
      tbl[5] = '{6'b110000, 6'b000011, 6'b110000};

      rst = 1'b1; valid_a = 1'b0; data_a = '0; ready_b = 1'b1;
      repeat (3) tick();
      check("rst_ready_a", ready_a_l, 0);
      check("rst_valid_b", valid_b_l, 0);
      check("rst_data_b",  data_b_l,  0);
      check("rst_last_b",  last_b_l,  0);
      rst = 1'b0;
      tick();
      check("post_rst_ready_a", ready_a_l, 1);

      // Single words, ready_b held high.
      for (int r = 0; r < 6; r++) begin
         data_a = tbl[r].word; valid_a = 1'b1;
         tick();
         valid_a = 1'b0;
         check("tbl_ready_a", ready_a_l, 1);
         seq_l = '0; seq_m = '0; last_s = '0; vld_s = '0;
         for (int i = 0; i < 6; i++) begin
            seq_l  = {seq_l[4:0],  data_b_l};
            seq_m  = {seq_m[4:0],  data_b_m};
            last_s = {last_s[4:0], last_b_l};
            vld_s  = {vld_s[4:0],  valid_b_l};
            tick();
         end
         check("tbl_seq_lsb",   seq_l,  tbl[r].exp_l);
         check("tbl_seq_msb",   seq_m,  tbl[r].exp_m);
         check("tbl_last",      last_s, 6'b000001);
         check("tbl_valid",     vld_s,  6'b111111);
         check("tbl_valid_end", valid_b_l, 0);
      end

      // Continuous stream of three words.
      words[0] = 6'h2A; words[1] = 6'h15; words[2] = 6'h3F;
      idx = 0; data_a = words[0]; valid_a = 1'b1;
      nv = 0; gaps = 0; seen_end = 1'b0; rdy_mask = '0; last_mask = '0;
      for (int c = 0; c < 40; c++) begin
         acc = valid_a && ready_a_l;
         tick();
         if (acc) begin
            idx++;
            if (idx < 3) data_a = words[idx];
            else valid_a = 1'b0;
         end
         if (valid_b_l) begin
            if (nv < 18) begin
               rdy_mask[nv]  = ready_a_l;
               last_mask[nv] = last_b_l;
            end
            nv++;
            if (seen_end) gaps++;
         end else if (nv > 0) begin
            seen_end = 1'b1;
         end
      end
      valid_a = 1'b0;
      check("stream_bits",  nv,   18);
      check("stream_gaps",  gaps, 0);
      check("stream_last",  last_mask, 18'b100000_100000_100000);
      check("stream_ready", rdy_mask,  18'b111111_000001_000001);

      // Backpressure at bit 2 for five cycles.
      n_out_l = 0;
      data_a = 6'b101100; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      tick(); tick();
      ready_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_data_l", data_b_l,  1);
         check("bp_data_m", data_b_m,  1);
         check("bp_valid",  valid_b_l, 1);
         check("bp_last",   last_b_l,  0);
      end
      ready_b = 1'b1;
      for (int i = 0; i < 10 && valid_b_l; i++) tick();
      check("bp_idle",       valid_b_l, 0);
      check("bp_total_bits", n_out_l, 6);

      // Final bit leaves while hold is full and valid_a stays high.
      n_out_l = 0;
      data_a = 6'h2A; valid_a = 1'b1;
      tick();
      data_a = 6'h15;
      tick();
      data_a = 6'h0F;
      check("hold_full_ready_a", ready_a_l, 0);
      for (int i = 0; i < 10 && !last_b_l; i++) tick();
      check("hold_last_seen",   last_b_l,  1);
      check("hold_ready_at_last", ready_a_l, 0);
      tick();
      check("hold_next_valid", valid_b_l, 1);
      check("hold_next_last",  last_b_l,  0);
      check("hold_next_lsb",   data_b_l,  1);
      check("hold_next_msb",   data_b_m,  0);
      check("hold_rdy_rise",   ready_a_l, 1);
      tick();
      valid_a = 1'b0;
      check("hold_refill_ready", ready_a_l, 0);
      for (int i = 0; i < 30 && valid_b_l; i++) tick();
      check("hold_idle",       valid_b_l, 0);
      check("hold_total_bits", n_out_l, 18);

      // Reset at bit 3 with the hold register full.
      data_a = 6'h2A; valid_a = 1'b1;
      tick();
      data_a = 6'h15;
      tick();
      valid_a = 1'b0;
      tick(); tick();
      check("mid_bit3_last", last_b_l, 0);
      rst = 1'b1;
      tick();
      check("mid_rst_ready_a", ready_a_l, 0);
      check("mid_rst_valid_b", valid_b_l, 0);
      check("mid_rst_data_b",  data_b_l,  0);
      check("mid_rst_last_b",  last_b_l,  0);
      check("mid_rst_valid_m", valid_b_m, 0);
      rst = 1'b0;
      tick();
      n_out_l = 0;
      check("mid_post_ready", ready_a_l, 1);
      check("mid_no_stale",   valid_b_l, 0);
      data_a = 6'b000111; valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
      check("mid_first_valid", valid_b_l, 1);
      check("mid_first_lsb",   data_b_l,  1);
      check("mid_first_msb",   data_b_m,  0);
      for (int i = 0; i < 10 && valid_b_l; i++) tick();
      check("mid_idle",       valid_b_l, 0);
      check("mid_total_bits", n_out_l, 6);

      tick();
      check("sb_l_empty", ql.size(), 0);
      check("sb_m_empty", qm.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
